serial_adder_nb: RTL and testbench

- Parametrised, bit-serial successor to the team's fixed-width ripple adders.
- Adds, subtracts or accumulates WIDTH-bit operands using one full-adder cell reused over WIDTH clock cycles, with a carry flip-flop between cycles.
- Uses a start/busy/done handshake and keeps its result registered.
- Sits between lab datapaths and the display/readout logic wherever area matters more than latency.

---
 rtl/serial_adder_nb.sv | 160 ++++++++++++++++
 tb/tb_serial_adder_nb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_nb.sv
// Bit-serial add/sub/accumulate engine: one full-adder cell reused over WIDTH cycles.
// Latency: start -> busy for WIDTH cycles -> done pulse in cycle WIDTH+1 (CLR: done in cycle 1).
// Backpressure: none; start is ignored while busy, accepted in IDLE or in the DONE cycle.
//
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   start, mode, a, b  : request; mode 00 ADD, 01 SUB, 10 ACC (sum+a), 11 CLR
//   busy, done         : busy during serial run, done one-cycle pulse when result lands
//   sum, cout, ovf     : registered result, carry out of MSB (SUB: 1 = no borrow), signed overflow
module serial_adder_nb #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_bit;
  logic             fa_carry;
  logic             last_bit;
  logic [WIDTH-1:0] res_shift;

  // The single full-adder cell working on the LSBs of the operand shifters.
  assign fa_bit    = opa_q[0] ^ opb_q[0] ^ c_q;
  assign fa_carry  = (opa_q[0] & opb_q[0]) | (opa_q[0] & c_q) | (opb_q[0] & c_q);
  assign last_bit  = (cnt_q == CW'(WIDTH - 1));
  assign res_shift = {fa_bit, res_q[WIDTH-1:1]};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = (mode == MODE_CLR) ? S_DONE : S_RUN;
        else       state_d = S_IDLE;
      end
      S_RUN:   if (last_bit) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    opa_d  = opa_q;
    opb_d  = opb_q;
    res_d  = res_q;
    c_d    = c_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          opa_d = a;
          res_d = '0;
          cnt_d = '0;
          c_d   = 1'b0;
          unique case (mode)
            MODE_ADD: opb_d = b;
            // Two's complement subtract: invert b and inject the +1 as carry-in.
            MODE_SUB: begin
              opb_d = ~b;
              c_d   = 1'b1;
            end
            // Accumulate against the result visible at the moment start is taken.
            MODE_ACC: opb_d = sum_q;
            MODE_CLR: begin
              opb_d  = '0;
              sum_d  = '0;
              cout_d = 1'b0;
              ovf_d  = 1'b0;
            end
            default: opb_d = b;
          endcase
        end
      end
      S_RUN: begin
        opa_d = opa_q >> 1;
        opb_d = opb_q >> 1;
        res_d = res_shift;
        c_d   = fa_carry;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          // On the MSB cycle c_q is the carry into the MSB; publish the result
          // together with the flags so sum never shows a partial value.
          sum_d  = res_shift;
          cout_d = fa_carry;
          ovf_d  = c_q ^ fa_carry;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    sum  = sum_q;
    cout = cout_q;
    ovf  = ovf_q;
  end

endmodule

// File: tb/tb_serial_adder_nb.sv
module tb_serial_adder_nb;

  localparam int W = 4;
  localparam logic [1:0] M_ADD = 2'b00;
  localparam logic [1:0] M_SUB = 2'b01;
  localparam logic [1:0] M_ACC = 2'b10;
  localparam logic [1:0] M_CLR = 2'b11;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [W-1:0] model_sum = '0;
  exp_t         sb_q[$];

  serial_adder_nb #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .mode (mode),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Word-level reference for one operation.
  function automatic exp_t model(input logic [1:0] m, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic [W-1:0] s);
    exp_t         e;
    logic [W:0]   full;
    logic [W-1:0] opb;
    logic         cin;
    cin = 1'b0;
    opb = y;
    case (m)
      M_SUB: begin opb = ~y; cin = 1'b1; end
      M_ACC: opb = s;
      default: ;
    endcase
    full   = {1'b0, x} + {1'b0, opb} + {{W{1'b0}}, cin};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (x[W-1] == opb[W-1]) && (full[W-1] != x[W-1]);
    e.cyc  = 0;
    if (m == M_CLR) begin
      e.sum = '0; e.cout = 1'b0; e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Drive a request for one edge; the expected result goes on the scoreboard.
  task automatic issue(input logic [1:0] m, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    start = 1'b1; mode = m; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = model(m, x, y, model_sum);
    e.cyc = (m == M_CLR) ? cyc : cyc + W;
    model_sum = e.sum;
    sb_q.push_back(e);
  endtask

  // Issue and follow the busy/done sequence; returns at the negedge of the DONE cycle.
  task automatic run_op(input logic [1:0] m, input logic [W-1:0] x, input logic [W-1:0] y);
    issue(m, x, y);
    if (m != M_CLR) begin
      for (int k = 0; k < W; k++) begin
        @(negedge clk);
        chk("busy_run", busy, 1);
        chk("done_run", done, 0);
      end
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 0);
  endtask

  // Scoreboard: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && done) chk("busy_and_done", 1, 0);
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_sum", sum, e.sum);
          chk("sb_cout", cout, e.cout);
          chk("sb_ovf", ovf, e.ovf);
          chk("sb_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD 3+5: signed overflow into the MSB
    run_op(M_ADD, 4'd3, 4'd5);
    chk("add35_sum", sum, 4'd8);
    chk("add35_cout", cout, 0);
    chk("add35_ovf", ovf, 1);
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);

    // SUB with and without borrow
    run_op(M_SUB, 4'd5, 4'd7);
    chk("sub57_sum", sum, 4'd14);
    chk("sub57_cout", cout, 0);
    @(negedge clk);
    run_op(M_SUB, 4'd7, 4'd5);
    chk("sub75_sum", sum, 4'd2);
    chk("sub75_cout", cout, 1);
    @(negedge clk);

    // Wrap-around, then CLR
    run_op(M_ADD, 4'd15, 4'd1);
    chk("add151_cout", cout, 1);
    @(negedge clk);
    run_op(M_CLR, 4'd9, 4'd9);
    chk("clr_sum", sum, 0);
    chk("clr_cout", cout, 0);
    @(negedge clk);

    // Accumulate twice
    run_op(M_CLR, 4'd0, 4'd0);
    run_op(M_ACC, 4'd6, 4'd3);
    chk("acc1_sum", sum, 4'd6);
    @(negedge clk);
    run_op(M_ACC, 4'd6, 4'd0);
    chk("acc2_sum", sum, 4'd12);
    chk("acc2_ovf", ovf, 1);
    @(negedge clk);

    // Start while busy is ignored; start in the DONE cycle is accepted
    issue(M_ADD, 4'd2, 4'd2);
    @(negedge clk);
    start = 1'b1; mode = M_SUB; a = 4'd9; b = 4'd1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && !done; k++) @(negedge clk);
    chk("b2b_first_done", done, 1);
    chk("b2b_first_sum", sum, 4'd4);
    run_op(M_ADD, 4'd1, 4'd1);
    chk("b2b_second_sum", sum, 4'd2);
    @(negedge clk);

    // Back-to-back random ops through the scoreboard
    for (int i = 0; i < 12; i++) begin
      run_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
    end
    @(negedge clk);

    // Reset during a run: the partial result must never surface
    issue(M_ADD, 4'd7, 4'd7);
    @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    model_sum = '0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sum", sum, 0);
    rst_n = 1'b1;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      chk("midrst_no_done", done, 0);
    end
    run_op(M_ADD, 4'd1, 4'd2);
    chk("post_rst_sum", sum, 4'd3);
    @(negedge clk);

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
